// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding AXI4-Lite initiator: turns a cmd/rsp handshake into one AW/W/B write
// or AR/R read transaction at a time.
module axi4lite_master_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WR    = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;
  localparam logic [2:0] RSP   = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    write_q, write_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  // Holds cmd_ready low until the first clock after reset release.
  logic                    init_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          resp_d    = '0;
          state_d   = cmd_write ? WR : RADDR;
        end
      end
      WR: begin
        aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d  = w_done_q | (m_axi_wvalid & m_axi_wready);
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          state_d = RSP;
        end
      end
      RADDR: begin
        if (m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      init_q    <= 1'b1;
    end
  end

  // All handshake outputs decode from registers only, so reset clears them asynchronously.
  assign cmd_ready     = init_q && (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT;
  assign m_axi_awvalid = (state_q == WR) && !aw_done_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = (state_q == WR) && !w_done_q;
  assign m_axi_bready  = (state_q == WRESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT;
  assign m_axi_arvalid = (state_q == RADDR);
  assign m_axi_rready  = (state_q == RDATA);
  assign rsp_valid     = (state_q == RSP);
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Directed bench for axi4lite_master_bridge with a small AXI4-Lite slave model (16-word memory,
// programmable ready delays and response codes).
module tb_axi4lite_master_bridge;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axi4lite_master_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Slave model knobs, set from the directed sequence.
  int       aw_dly = 0;
  int       w_dly = 0;
  logic [1:0] bresp_v = 2'b00;
  logic [1:0] rresp_v = 2'b00;

  int          aw_wait, w_wait;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_addr_s, w_data_s, r_data_s, wa, wd;
  logic [3:0]  w_strb_s, ws;
  logic [31:0] mem [16];
  int          aw_cyc, w_cyc, ar_cyc, b_cnt, r_cnt, aw_edge, w_edge, ar_edge;

  wire aw_hs = m_axi_awvalid && m_axi_awready;
  wire w_hs  = m_axi_wvalid && m_axi_wready;
  wire ar_hs = m_axi_arvalid && m_axi_arready;
  assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid && (w_wait >= w_dly);
  assign m_axi_arready = m_axi_arvalid;
  assign m_axi_bvalid  = b_pend;
  assign m_axi_bresp   = bresp_v;
  assign m_axi_rvalid  = r_pend;
  assign m_axi_rdata   = r_data_s;
  assign m_axi_rresp   = rresp_v;
  assign wa = aw_hs ? m_axi_awaddr : aw_addr_s;
  assign wd = w_hs ? m_axi_wdata : w_data_s;
  assign ws = w_hs ? m_axi_wstrb : w_strb_s;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_wait <= 0; w_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0; r_data_s <= '0;
      aw_cyc <= 0; w_cyc <= 0; ar_cyc <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_edge <= 0; w_edge <= 0; ar_edge <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hFFFF_FFFF;
      mem[1] <= 32'h0003_0002;
      mem[2] <= 32'h1234_5678;
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      if (m_axi_awvalid) aw_cyc <= aw_cyc + 1;
      if (m_axi_wvalid) w_cyc <= w_cyc + 1;
      if (m_axi_arvalid) ar_cyc <= ar_cyc + 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= m_axi_awaddr; aw_edge <= cyc + 1; end
      if (w_hs) begin
        w_got <= 1'b1; w_data_s <= m_axi_wdata; w_strb_s <= m_axi_wstrb; w_edge <= cyc + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        for (int b = 0; b < 4; b++) if (ws[b]) mem[wa[5:2]][8*b +: 8] <= wd[8*b +: 8];
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (b_pend && m_axi_bready) begin b_pend <= 1'b0; b_cnt <= b_cnt + 1; end
      if (ar_hs) begin r_pend <= 1'b1; r_data_s <= mem[m_axi_araddr[5:2]]; ar_edge <= cyc + 1; end
      if (r_pend && m_axi_rready) begin r_pend <= 1'b0; r_cnt <= r_cnt + 1; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int acc, seen, hs;

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic ok = 1'b0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    chk("cmd_accept", {31'd0, ok}, 32'd1);
  endtask

  // Leaves time at a falling edge where rsp_valid was first seen; seen = edge it is sampled at.
  task automatic wait_rsp();
    logic ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (rsp_valid) begin ok = 1'b1; seen = cyc + 1; break; end
    end
    chk("rsp_valid_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(posedge aclk); #1;
    hs = cyc;
    rsp_ready = 1'b0;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  int acc1, snap_aw, snap_w, snap_ar, snap_b;

  initial begin
    // Reset state.
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valids", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                       m_axi_rready, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: full write, always-ready slave.
    send_cmd(1'b1, 32'h0, 32'hA5A5_0001, 4'hF);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    wait_rsp();
    chk("t1_aw_edge", aw_edge - acc, 32'd1);
    chk("t1_w_edge", w_edge - acc, 32'd1);
    chk("t1_rsp_lat", seen - acc, 32'd3);
    chk("t1_resp", {30'd0, rsp_resp}, 32'd0);
    chk("t1_write", {31'd0, rsp_write}, 32'd1);
    chk("t1_rdata", rsp_rdata, 32'd0);
    chk("t1_mem", mem[0], 32'hA5A5_0001);
    chk("t1_b_cnt", b_cnt, 32'd1);
    acc1 = acc;
    rsp_handshake();

    // 2: read back-to-back, expected acceptance at N+4.
    snap_ar = ar_cyc;
    send_cmd(1'b0, 32'h4, 32'hDEAD_BEEF, 4'h0);
    chk("t2_b2b_accept", acc - acc1, 32'd4);
    wait_rsp();
    chk("t2_ar_cycles", ar_cyc - snap_ar, 32'd1);
    chk("t2_ar_edge", ar_edge - acc, 32'd1);
    chk("t2_rsp_lat", seen - acc, 32'd3);
    chk("t2_rdata", rsp_rdata, 32'h0003_0002);
    chk("t2_resp", {30'd0, rsp_resp}, 32'd0);
    chk("t2_write", {31'd0, rsp_write}, 32'd0);
    rsp_handshake();

    // 3: awready delayed 3 cycles, wready immediate.
    aw_dly = 3;
    snap_aw = aw_cyc; snap_w = w_cyc; snap_b = b_cnt;
    send_cmd(1'b1, 32'h14, 32'h0BAD_F00D, 4'hF);
    wait_rsp();
    chk("t3_aw_cycles", aw_cyc - snap_aw, 32'd4);
    chk("t3_w_cycles", w_cyc - snap_w, 32'd1);
    chk("t3_b_count", b_cnt - snap_b, 32'd1);
    chk("t3_rsp_lat", seen - acc, 32'd6);
    chk("t3_mem", mem[5], 32'h0BAD_F00D);
    rsp_handshake();
    aw_dly = 0;

    // 4: rsp_ready held low 5 cycles on a read.
    snap_aw = aw_cyc; snap_ar = ar_cyc;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    wait_rsp();
    snap_ar = ar_cyc;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t4_hold_rdata", rsp_rdata, 32'h0003_0002);
      chk("t4_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    chk("t4_no_ar", ar_cyc - snap_ar, 32'd0);
    chk("t4_no_aw", aw_cyc - snap_aw, 32'd0);
    rsp_handshake();
    send_cmd(1'b1, 32'h18, 32'h5555_AAAA, 4'hF);
    chk("t4_next_accept", acc - hs, 32'd1);
    wait_rsp();
    chk("t4_next_write", {31'd0, rsp_write}, 32'd1);
    rsp_handshake();

    // 5: read returning SLVERR.
    rresp_v = 2'b10;
    send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
    wait_rsp();
    chk("t5_resp", {30'd0, rsp_resp}, 32'd2);
    chk("t5_rdata", rsp_rdata, 32'h1234_5678);
    rsp_handshake();
    rresp_v = 2'b00;

    // 6: asynchronous reset while awvalid waits on awready.
    aw_dly = 10;
    send_cmd(1'b1, 32'h1C, 32'h7777_7777, 4'hF);
    @(negedge aclk); @(negedge aclk);
    chk("t6_aw_pending", {31'd0, m_axi_awvalid}, 32'd1);
    #1 aresetn = 1'b0;
    #1;
    chk("t6_rst_valids", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                          m_axi_rready, rsp_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    aw_dly = 0;
    @(negedge aclk); aresetn = 1'b1;
    #1 chk("t6_release_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge aclk); #1;
    chk("t6_first_clk_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    send_cmd(1'b1, 32'hC, 32'hAA11_BB33, 4'b0101);
    wait_rsp();
    chk("t6_resp", {30'd0, rsp_resp}, 32'd0);
    chk("t6_rsp_lat", seen - acc, 32'd3);
    chk("t6_mem_strobe", mem[3], 32'hFF11_FF33);
    chk("t6_mem_untouched", mem[7], 32'hFFFF_FFFF);
    rsp_handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
